// File: rtl/logic_analyzer_capture.sv
// Capture front end: probe synchroniser, sample strobe, trigger and byte
// packing into per-channel FIFOs, followed by readout requests per channel.
module logic_analyzer_capture #(
    parameter int DIV_W        = 16,
    parameter int SAMPLE_BYTES = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       ch_in,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       ch_mask,
    input  logic [1:0]       trig_mode,
    input  logic [1:0]       trig_ch,
    input  logic [DIV_W-1:0] div,
    input  logic [3:0]       fifo_full,
    input  logic [3:0]       fifo_empty,
    output logic [3:0]       fifo_wr_req,
    output logic [7:0]       fifo_wr_data0,
    output logic [7:0]       fifo_wr_data1,
    output logic [7:0]       fifo_wr_data2,
    output logic [7:0]       fifo_wr_data3,
    output logic             en0,
    output logic             en1,
    output logic             en2,
    output logic             en3,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam int BC_W = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(SAMPLE_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [3:0]           sync1_q, sync_q;
    logic [3:0]           prev_q, prev_d;
    logic [3:0]           mask_q, mask_d;
    logic [1:0]           mode_q, mode_d;
    logic [1:0]           tch_q, tch_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic                 first_q, first_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [BC_W-1:0]      byte_cnt_q, byte_cnt_d;
    logic [3:0][7:0]      sh_q, sh_d;
    logic [3:0][7:0]      data_q, data_d;
    logic                 wr_pend_q, wr_pend_d;
    logic [3:0]           en_q, en_d;
    logic                 ovf_q, ovf_d;

    logic                 strobe;
    logic                 trig_s, trig_p;
    logic                 fire;

    // Next-state logic for the FSM and all datapath registers
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        mask_d     = mask_q;
        mode_d     = mode_q;
        tch_d      = tch_q;
        div_d      = div_q;
        first_d    = first_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        sh_d       = sh_q;
        data_d     = data_q;
        wr_pend_d  = 1'b0;
        en_d       = en_q;
        ovf_d      = ovf_q;

        strobe = (cnt_q == div_q);
        cnt_d  = strobe ? '0 : cnt_q + DIV_W'(1);
        if (strobe) prev_d = sync_q;

        trig_s = sync_q[tch_q];
        trig_p = prev_q[tch_q];
        case (mode_q)
            2'd0:    fire = 1'b1;
            2'd1:    fire = ~first_q & trig_s & ~trig_p;
            2'd2:    fire = ~first_q & ~trig_s & trig_p;
            default: fire = ~first_q & (trig_s ^ trig_p);
        endcase

        if (abort) begin
            // abort beats start; overflow survives, the partial byte does not
            state_d   = S_IDLE;
            en_d      = '0;
            bit_cnt_d = '0;
        end else begin
            // write cycle following a completed byte
            if (wr_pend_q) begin
                byte_cnt_d = byte_cnt_q + BC_W'(1);
                if (|(mask_q & fifo_full)) ovf_d = 1'b1;
                if (byte_cnt_q == LAST_BYTE) state_d = S_DONE;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d    = S_ARM;
                        mask_d     = ch_mask;
                        mode_d     = trig_mode;
                        tch_d      = trig_ch;
                        div_d      = div;
                        cnt_d      = '0;
                        first_d    = 1'b1;
                        ovf_d      = 1'b0;
                        byte_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end
                end
                S_ARM: begin
                    if (strobe) begin
                        first_d = 1'b0;
                        if (fire) begin
                            // the firing sample is bit 0 of the first byte
                            state_d = S_CAPTURE;
                            for (int i = 0; i < 4; i++) sh_d[i][0] = sync_q[i];
                            bit_cnt_d = 3'd1;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (strobe) begin
                        for (int i = 0; i < 4; i++) sh_d[i][bit_cnt_q] = sync_q[i];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            wr_pend_d = 1'b1;
                            for (int i = 0; i < 4; i++)
                                data_d[i] = {sync_q[i], sh_q[i][6:0]};
                        end
                    end
                end
                default: begin
                    // readout: request every masked channel still holding data
                    en_d = mask_q & ~fifo_empty;
                    if ((fifo_empty & mask_q) == mask_q) begin
                        state_d = S_IDLE;
                        en_d    = '0;
                    end
                end
            endcase
        end
    end

    // State, synchroniser and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            sync1_q    <= '0;
            sync_q     <= '0;
            prev_q     <= '0;
            mask_q     <= '0;
            mode_q     <= '0;
            tch_q      <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            sh_q       <= '0;
            data_q     <= '0;
            wr_pend_q  <= 1'b0;
            en_q       <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= ch_in;
            sync_q     <= sync1_q;
            prev_q     <= prev_d;
            mask_q     <= mask_d;
            mode_q     <= mode_d;
            tch_q      <= tch_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            sh_q       <= sh_d;
            data_q     <= data_d;
            wr_pend_q  <= wr_pend_d;
            en_q       <= en_d;
            ovf_q      <= ovf_d;
        end
    end

    assign fifo_wr_req   = {4{wr_pend_q}} & mask_q & ~fifo_full;
    assign fifo_wr_data0 = data_q[0];
    assign fifo_wr_data1 = data_q[1];
    assign fifo_wr_data2 = data_q[2];
    assign fifo_wr_data3 = data_q[3];
    assign en0           = en_q[0];
    assign en1           = en_q[1];
    assign en2           = en_q[2];
    assign en3           = en_q[3];
    assign busy          = (state_q == S_ARM) || (state_q == S_CAPTURE);
    assign done          = (state_q == S_DONE);
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_logic_analyzer_capture.sv
// Scoreboard bench for logic_analyzer_capture (SAMPLE_BYTES=2).
module tb_logic_analyzer_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  ch_in;
    logic        start, abort;
    logic [3:0]  ch_mask;
    logic [1:0]  trig_mode, trig_ch;
    logic [15:0] div;
    logic [3:0]  fifo_full, fifo_empty;
    logic [3:0]  fifo_wr_req;
    logic [7:0]  fifo_wr_data0, fifo_wr_data1, fifo_wr_data2, fifo_wr_data3;
    logic        en0, en1, en2, en3, busy, done, overflow;

    logic [3:0]  ch_base;
    logic        tog_en;
    logic        tog_q = 1'b0;
    int          cyc = 0;
    int          last_wr0 = 0;
    int          wr_gap0 = 0;
    int          wr_total = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct packed { logic [7:0] d; logic [7:0] alt; } exp_t;
    exp_t        sbq [4][$];
    logic [7:0]  wd [4];

    assign ch_in = ch_base ^ {3'b000, tog_q};
    assign wd[0] = fifo_wr_data0;
    assign wd[1] = fifo_wr_data1;
    assign wd[2] = fifo_wr_data2;
    assign wd[3] = fifo_wr_data3;

    logic_analyzer_capture #(.DIV_W(16), .SAMPLE_BYTES(2)) dut (
        .clk(clk), .reset_n(reset_n), .ch_in(ch_in), .start(start), .abort(abort),
        .ch_mask(ch_mask), .trig_mode(trig_mode), .trig_ch(trig_ch), .div(div),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_wr_req(fifo_wr_req),
        .fifo_wr_data0(fifo_wr_data0), .fifo_wr_data1(fifo_wr_data1),
        .fifo_wr_data2(fifo_wr_data2), .fifo_wr_data3(fifo_wr_data3),
        .en0(en0), .en1(en1), .en2(en2), .en3(en3),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // probe 0 toggle generator
    always @(negedge clk) tog_q <= tog_en ? ~tog_q : 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    // write monitor: pop the scoreboard on every FIFO write strobe
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (fifo_wr_req[i]) begin
                exp_t e;
                wr_total++;
                if (sbq[i].size() == 0) begin
                    chk($sformatf("wr_unexp_ch%0d", i), 32'(fifo_wr_req[i]), 32'd0);
                end else begin
                    e = sbq[i].pop_front();
                    chk($sformatf("wr_data_ch%0d", i), 32'(wd[i]),
                        (wd[i] == e.alt) ? 32'(e.alt) : 32'(e.d));
                end
                if (i == 0) begin
                    wr_gap0  = cyc - last_wr0;
                    last_wr0 = cyc;
                end
            end
        end
    end

    task automatic push(input int ch, input logic [7:0] d, input logic [7:0] alt);
        exp_t e;
        e.d = d; e.alt = alt;
        sbq[ch].push_back(e);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        while (!done && n < maxc) begin @(negedge clk); n++; end
        chk("tmo_done", 32'(done), 32'd1);
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((busy || done) && n < maxc) begin @(negedge clk); n++; end
        chk("tmo_idle", 32'(busy | done), 32'd0);
    endtask

    task automatic chk_queues(input string tag);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_left_ch%0d", tag, i), 32'(sbq[i].size()), 32'd0);
    endtask

    initial begin
        int snap;
        reset_n = 1'b0; start = 0; abort = 0; ch_mask = 0; trig_mode = 0; trig_ch = 0;
        div = 0; fifo_full = 0; fifo_empty = 4'hF; ch_base = 0; tog_en = 0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {25'd0, busy, done, overflow, en3, en2, en1, en0}, 32'd0);
        chk("rst_wr", {28'd0, fifo_wr_req}, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // immediate trigger, div 0, toggling probe 0, readout hold on ch0
        ch_mask = 4'b0001; trig_mode = 0; div = 0; fifo_empty = 4'b1110; tog_en = 1;
        push(0, 8'h55, 8'hAA); push(0, 8'h55, 8'hAA);
        pulse_start();
        wait_done(100);
        tog_en = 0;
        chk("t1_gap", 32'(wr_gap0), 32'd8);
        repeat (2) @(negedge clk);
        chk("t1_done_en", {29'd0, done, en0, en1}, 32'b110);
        fifo_empty[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("t1_exit", {29'd0, done, en0, busy}, 32'd0);
        chk_queues("t1");

        // rising trigger on ch2, div 3
        ch_base = 4'b0001; ch_mask = 4'b0101; trig_mode = 1; trig_ch = 2; div = 3;
        repeat (4) @(negedge clk);
        snap = wr_total;
        pulse_start();
        repeat (8) @(posedge clk);
        #1;
        chk("t2_no_early_wr", 32'(wr_total - snap), 32'd0);
        chk("t2_armed", 32'(busy), 32'd1);
        ch_base = 4'b0101;
        push(0, 8'hFF, 8'hFF); push(0, 8'hFF, 8'hFF);
        push(2, 8'hFF, 8'hFF); push(2, 8'hFF, 8'hFF);
        wait_idle(300);
        chk_queues("t2");

        // full FIFO on ch1 during second write
        ch_base = 4'b0001; ch_mask = 4'b0011; trig_mode = 0; div = 0;
        push(0, 8'hFF, 8'hFF); push(0, 8'hFF, 8'hFF); push(1, 8'h00, 8'h00);
        pulse_start();
        repeat (12) @(negedge clk);
        fifo_full[1] = 1'b1;
        wait_idle(100);
        fifo_full = 0;
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk_queues("t3");

        // readout of ch1 and ch3, step on ch3 checks bit order
        ch_base = 4'b0000; ch_mask = 4'b1010; trig_mode = 0; div = 3; fifo_empty = 4'b0101;
        push(1, 8'h00, 8'h00); push(1, 8'h00, 8'h00);
        push(3, 8'hF8, 8'hF8); push(3, 8'hFF, 8'hFF);
        pulse_start();
        chk("t4_ovf_clr", 32'(overflow), 32'd0);
        repeat (12) @(posedge clk);
        #1 ch_base = 4'b1000;
        wait_done(200);
        repeat (2) @(negedge clk);
        chk("t4_en", {28'd0, en3, en2, en1, en0}, 32'b1010);
        fifo_empty[1] = 1'b1;
        @(negedge clk);
        chk("t4_en_drain1", {27'd0, done, en3, en2, en1, en0}, 32'b11000);
        fifo_empty[3] = 1'b1;
        repeat (2) @(negedge clk);
        chk("t4_exit", {27'd0, done, en3, en2, en1, en0}, 32'd0);
        chk_queues("t4");

        // abort after 5 samples, then rerun must start from bit 0
        ch_base = 4'b0001; ch_mask = 4'b0001; div = 3;
        pulse_start();
        repeat (21) @(posedge clk);
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("t5_abort_idle", {30'd0, busy, done}, 32'd0);
        repeat (40) @(negedge clk);
        ch_base = 4'b0000;
        push(0, 8'h00, 8'h00); push(0, 8'h00, 8'h00);
        pulse_start();
        wait_idle(300);
        chk_queues("t5");

        // start while busy must not reload div
        ch_base = 4'b0001; div = 3;
        push(0, 8'hFF, 8'hFF); push(0, 8'hFF, 8'hFF);
        pulse_start();
        repeat (3) @(negedge clk);
        div = 0;
        pulse_start();
        wait_idle(300);
        chk("t6_gap", 32'(wr_gap0), 32'd32);
        chk_queues("t6");

        // reset mid-run
        div = 3;
        pulse_start();
        repeat (10) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("t7_rst_ctl", {25'd0, busy, done, overflow, en3, en2, en1, en0}, 32'd0);
        chk("t7_rst_data", {fifo_wr_data3, fifo_wr_data2, fifo_wr_data1, fifo_wr_data0}, 32'd0);
        chk("t7_rst_wr", {28'd0, fifo_wr_req}, 32'd0);
        @(negedge clk); reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t7_after", {30'd0, busy, done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
